// File: rtl/nios_mul_pkg.sv
// Shared types and constants for the multiplier combine stage.
// Build option MUL_COMBINE_FULL64_EN is consumed by nios_mul_combine.
package nios_mul_pkg;

  localparam int DATA_W = 32;
  localparam int PP_W   = 32;
  localparam int MID_W  = 34;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } mul_op_t;

  // Stage A payload: folded middle partials plus the untouched outer partials.
  typedef struct packed {
    logic [MID_W-1:0] mid;
    logic [PP_W-1:0]  p1;
    logic [PP_W-1:0]  p4;
    logic             p4_signed;
    mul_op_t          op;
  } stage_a_t;

  function automatic logic op_src1_signed(input mul_op_t op);
    return (op == MULXSU) || (op == MULXSS);
  endfunction

  function automatic logic op_src2_signed(input mul_op_t op);
    return (op == MULXSS);
  endfunction

endpackage

// File: rtl/nios_mul_stage_reg.sv
// Generic valid/ready pipeline register; data only loads on an accepted beat.
module nios_mul_stage_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d;
  logic         valid_q;
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;
  logic         load_s;

  // Next-state: load on accept, drain on downstream take, otherwise hold.
  always_comb begin
    in_ready = ~valid_q | out_ready;
    load_s   = in_valid & in_ready;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/nios_mul_combine.sv
// Combines four 16x16 partial products into the 32-bit MUL/MULX result (2-stage pipe).
// Define MUL_COMBINE_FULL64_EN to expose the registered high word on out_result_hi.
module nios_mul_combine
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PP_W   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_p1,
  input  logic [31:0] in_p2,
  input  logic [31:0] in_p3,
  input  logic [31:0] in_p4,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef MUL_COMBINE_FULL64_EN
  output logic [31:0] out_result_hi,
`endif
  output logic [31:0] out_result
);

  if ((DATA_W != 32) || (PP_W != DATA_W)) begin : g_param_check
    $error("nios_mul_combine: only DATA_W = PP_W = 32 is supported");
  end

`ifdef MUL_COMBINE_FULL64_EN
  localparam int B_W = 64;
`else
  localparam int B_W = 32;
`endif

  mul_op_t        op_s;
  logic           s1_s;
  logic           s2_s;
  stage_a_t       a_in_s;
  stage_a_t       a_out_s;
  logic           a_valid_s;
  logic           b_ready_s;
  logic [63:0]    p4_ext_s;
  logic [63:0]    full_s;
  logic [31:0]    res_lo_s;
  logic [B_W-1:0] b_in_s;
  logic [B_W-1:0] b_out_s;

  // Stage A: fold the two cross partials into one 34-bit middle term.
  always_comb begin
    op_s             = mul_op_t'(in_op);
    s1_s             = op_src1_signed(op_s);
    s2_s             = op_src2_signed(op_s);
    a_in_s.mid       = {{2{s2_s & in_p2[31]}}, in_p2} + {{2{s1_s & in_p3[31]}}, in_p3};
    a_in_s.p1        = in_p1;
    a_in_s.p4        = in_p4;
    a_in_s.p4_signed = s1_s | s2_s;
    a_in_s.op        = op_s;
  end

  nios_mul_stage_reg #(
    .W($bits(stage_a_t))
  ) u_stage_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (a_in_s),
    .out_valid(a_valid_s),
    .out_ready(b_ready_s),
    .out_data (a_out_s)
  );

  // Stage B: assemble the 64-bit product; p4's extension bits fall off the top mod 2^64.
  always_comb begin
    p4_ext_s = {{32{a_out_s.p4_signed & a_out_s.p4[31]}}, a_out_s.p4};
    full_s   = {32'h0000_0000, a_out_s.p1}
             + {{14{a_out_s.mid[33]}}, a_out_s.mid, 16'h0000}
             + (p4_ext_s << 6'd32);
    case (a_out_s.op)
      MUL_LO:                 res_lo_s = full_s[31:0];
      MULXUU, MULXSU, MULXSS: res_lo_s = full_s[63:32];
      default:                res_lo_s = full_s[31:0];
    endcase
  end

`ifdef MUL_COMBINE_FULL64_EN
  assign b_in_s        = {full_s[63:32], res_lo_s};
  assign out_result    = b_out_s[31:0];
  assign out_result_hi = b_out_s[63:32];
`else
  assign b_in_s        = res_lo_s;
  assign out_result    = b_out_s;
`endif

  nios_mul_stage_reg #(
    .W(B_W)
  ) u_stage_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (a_valid_s),
    .in_ready (b_ready_s),
    .in_data  (b_in_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (b_out_s)
  );

endmodule

// File: tb/tb_nios_mul_combine.sv
// Self-checking bench for nios_mul_combine: directed vectors, handshake corners and
// randomized operands checked against a full-product reference model.
module tb_nios_mul_combine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_p1 = 32'd0;
  logic [31:0] in_p2 = 32'd0;
  logic [31:0] in_p3 = 32'd0;
  logic [31:0] in_p4 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
`ifdef MUL_COMBINE_FULL64_EN
  logic [31:0] out_result_hi;
`endif

  nios_mul_combine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_p1     (in_p1),
    .in_p2     (in_p2),
    .in_p3     (in_p3),
    .in_p4     (in_p4),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUL_COMBINE_FULL64_EN
    .out_result_hi(out_result_hi),
`endif
    .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    bit          chk_hi;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b1;
  bit          rnd_rdy = 1'b0;
  bit          hold_vld = 1'b0;
  logic [31:0] hold_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: true signed/unsigned product of the source operands, and the
  // partials the upstream multiplier cell would hand over for them.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p1, output logic [31:0] p2,
                                output logic [31:0] p3, output logic [31:0] p4,
                                output logic [63:0] full);
    bit s1 = (op == 2'd2) || (op == 2'd3);
    bit s2 = (op == 2'd3);
    longint l1 = longint'({16'h0000, a[15:0]});
    longint l2 = longint'({16'h0000, b[15:0]});
    longint h1 = s1 ? longint'($signed(a[31:16])) : longint'({16'h0000, a[31:16]});
    longint h2 = s2 ? longint'($signed(b[31:16])) : longint'({16'h0000, b[31:16]});
    longint fa = s1 ? longint'($signed(a)) : longint'({32'h0, a});
    longint fb = s2 ? longint'($signed(b)) : longint'({32'h0, b});
    longint t;
    t = l1 * l2; p1 = t[31:0];
    t = l1 * h2; p2 = t[31:0];
    t = h1 * l2; p3 = t[31:0];
    t = h1 * h2; p4 = t[31:0];
    t = fa * fb; full = t;
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] p3, input logic [31:0] p4,
                      input logic [31:0] er, input logic [31:0] eh, input bit ch);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1; in_op = op;
    in_p1 = p1; in_p2 = p2; in_p3 = p3; in_p4 = p4;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    else begin
      e.res = er; e.hi = eh; e.chk_hi = ch; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    logic [1:0]  op;
    logic [31:0] a, b, p1, p2, p3, p4;
    logic [63:0] full;
    op = 2'($urandom_range(0, 3));
    a  = $urandom;
    b  = $urandom;
    case ($urandom_range(0, 7))
      0: a = 32'h8000_0000;
      1: b = 32'hFFFF_FFFF;
      default: ;
    endcase
    model(op, a, b, p1, p2, p3, p4, full);
    send(op, p1, p2, p3, p4, (op == 2'd0) ? full[31:0] : full[63:32], full[63:32], 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Output monitor: scoreboard pops, latency, and hold-stability under backpressure.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) hold_vld = 1'b0;
      else begin
        if (hold_vld) begin
          check("hold_valid", {63'd0, out_valid}, 64'd1);
          check("hold_result", {32'd0, out_result}, {32'd0, hold_res});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("unexpected_out", {63'd0, out_valid}, 64'd0);
          else begin
            e = sb.pop_front();
            check("result", {32'd0, out_result}, {32'd0, e.res});
`ifdef MUL_COMBINE_FULL64_EN
            if (e.chk_hi) check("result_hi", {32'd0, out_result_hi}, {32'd0, e.hi});
`endif
            if (lat_chk) check("latency", 64'(cyc), 64'(e.acc + 2));
          end
        end
        hold_vld = out_valid && !out_ready;
        hold_res = out_result;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset and post-reset state.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors.
    send(2'd1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFFFFFE, 32'd0, 1'b0);
    send(2'd0, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h00000001, 32'd0, 1'b0);
    send(2'd3, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 32'h00000000, 32'd0, 1'b0);
    send(2'd0, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 32'h00000001, 32'd0, 1'b0);
    send(2'd2, 32'h00000000, 32'h00000000, 32'hFFFF0000, 32'h00000000, 32'hFFFFFFFF, 32'd0, 1'b0);
    idle(4);

    // Back-to-back random ops, no backpressure: latency checked per result.
    repeat (4) send_rand();
    idle(4);

    // Backpressure: two accepts fill the pipe, then in_ready must stay low.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    send_rand();
    send_rand();
    in_valid = 1'b1;
    in_p1 = $urandom;
    repeat (5) begin
      @(negedge clk);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_rand();
    idle(5);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full: stale results must never emerge.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_result", {32'd0, out_result}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef MUL_COMBINE_FULL64_EN
    check("midrst_result_hi", {32'd0, out_result_hi}, 64'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);

    // Randomized stream with random backpressure and input gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    in_valid = 1'b0;
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
